// File: rtl/regfile_sipo_pkg.sv
// regfile_sipo_pkg: shared sizes and types for the five-wide read window register file
package regfile_sipo_pkg;
    localparam int DATA_SIZE = 32;
    localparam int ADDR_SIZE = 7;
    localparam int REG_SIZE = 2 ** ADDR_SIZE;
    localparam int WINDOW = 5;
    typedef logic [DATA_SIZE-1:0] word_t;
    typedef logic [ADDR_SIZE-1:0] addr_t;
endpackage

// File: rtl/regfile_window_mux.sv
// regfile_window_mux: selects WINDOW consecutive words from base, wrapping at the array end
module regfile_window_mux
    import regfile_sipo_pkg::*;
#(
    parameter int DATA_SIZE = regfile_sipo_pkg::DATA_SIZE,
    parameter int ADDR_SIZE = regfile_sipo_pkg::ADDR_SIZE
) (
    input  logic [DATA_SIZE-1:0] regs [2**ADDR_SIZE],
    input  logic [ADDR_SIZE-1:0] base,
    output logic [DATA_SIZE-1:0] win  [WINDOW]
);
    for (genvar k = 0; k < WINDOW; k++) begin : g_win
        logic [ADDR_SIZE-1:0] idx;
        assign idx = base + ADDR_SIZE'(k);
        assign win[k] = regs[idx];
    end
endmodule

// File: rtl/regfile_sipo.sv
// regfile_sipo: single-write register file presenting five consecutive words per read
module regfile_sipo
    import regfile_sipo_pkg::*;
#(
    parameter int DATA_SIZE = regfile_sipo_pkg::DATA_SIZE,
    parameter int ADDR_SIZE = regfile_sipo_pkg::ADDR_SIZE,
    parameter int REG_SIZE = 2 ** ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_enable,
    input  logic                 reg_write,
    input  logic [ADDR_SIZE-1:0] src_addr,
    input  logic [ADDR_SIZE-1:0] write_addr,
    input  logic [DATA_SIZE-1:0] write_data,
    output logic [DATA_SIZE-1:0] src1,
    output logic [DATA_SIZE-1:0] src2,
    output logic [DATA_SIZE-1:0] src3,
    output logic [DATA_SIZE-1:0] src4,
    output logic [DATA_SIZE-1:0] src5
);
    logic [DATA_SIZE-1:0] REG [REG_SIZE];
    logic [DATA_SIZE-1:0] win [WINDOW];

    regfile_window_mux #(.DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE)) u_mux (
        .regs(REG),
        .base(src_addr),
        .win (win)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < REG_SIZE; i++) REG[i] <= '0;
        else if (reg_enable && reg_write)
            REG[write_addr] <= write_data;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            src1 <= '0;
            src2 <= '0;
            src3 <= '0;
            src4 <= '0;
            src5 <= '0;
        end else if (reg_enable && !reg_write) begin
            src1 <= win[0];
            src2 <= win[1];
            src3 <= win[2];
            src4 <= win[3];
            src5 <= win[4];
        end
endmodule

// File: tb/tb_regfile_sipo.sv
// tb_regfile_sipo: table-driven check of writes, windowed reads, hold and async reset
module tb_regfile_sipo;
    logic clk = 0, rst = 0, en = 0, wr = 0;
    logic [6:0] sa = 0, wa = 0;
    logic [31:0] wd = 0;
    logic [31:0] s1, s2, s3, s4, s5;
    logic [4:0][31:0] s;
    int n_chk = 0, n_fail = 0;

    typedef struct {
        logic en, wr;
        logic [6:0] sa, wa;
        logic [31:0] wd;
        logic chk;
        logic [4:0][31:0] e;
    } vec_t;
    vec_t vq[$];

    assign s = {s5, s4, s3, s2, s1};
    always #5 clk = ~clk;

    regfile_sipo dut (
        .clk(clk), .rst(rst), .reg_enable(en), .reg_write(wr),
        .src_addr(sa), .write_addr(wa), .write_data(wd),
        .src1(s1), .src2(s2), .src3(s3), .src4(s4), .src5(s5)
    );

    function automatic logic [4:0][31:0] w5(logic [31:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_win(string nm, logic [4:0][31:0] e);
        for (int k = 0; k < 5; k++) check($sformatf("%s src%0d", nm, k + 1), s[k], e[k]);
    endtask

    task automatic add(logic e_, logic w_, logic [6:0] sa_, logic [6:0] wa_, logic [31:0] wd_,
                       logic c_, logic [4:0][31:0] ex);
        vec_t v;
        v.en = e_; v.wr = w_; v.sa = sa_; v.wa = wa_; v.wd = wd_; v.chk = c_; v.e = ex;
        vq.push_back(v);
    endtask

    task automatic step(logic e_, logic w_, logic [6:0] sa_, logic [6:0] wa_, logic [31:0] wd_);
        en = e_; wr = w_; sa = sa_; wa = wa_; wd = wd_;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] acc;
        logic [4:0][31:0] z;
        logic [4:0][31:0] wrapw;
        z = '0;
        wrapw = w5(32'hA, 32'hB, 32'hC, 32'hD, 32'hE);

        for (int i = 0; i < 5; i++) add(1, 1, 7'd99, 7'(i), 32'hFFFF0000 + i, 0, z);
        add(1, 0, 7'd0, 7'd50, 32'h0, 1, w5(32'hFFFF0000, 32'hFFFF0001, 32'hFFFF0002, 32'hFFFF0003, 32'hFFFF0004));
        for (int i = 0; i < 5; i++) add(1, 1, 7'd3, 7'(120 + i), 32'hFFFF0000 + i, 0, z);
        add(1, 0, 7'd120, 7'd0, 32'h0, 1, w5(32'hFFFF0000, 32'hFFFF0001, 32'hFFFF0002, 32'hFFFF0003, 32'hFFFF0004));
        add(1, 1, 0, 7'd126, 32'hA, 0, z);
        add(1, 1, 0, 7'd127, 32'hB, 0, z);
        add(1, 1, 0, 7'd0, 32'hC, 0, z);
        add(1, 1, 0, 7'd1, 32'hD, 0, z);
        add(1, 1, 0, 7'd2, 32'hE, 0, z);
        add(1, 0, 7'd126, 7'd5, 32'h0, 1, wrapw);
        for (int i = 0; i < 3; i++) add(0, 1, 7'(5 + i), 7'd126, 32'hDEAD0000 + i, 1, wrapw);
        add(0, 0, 7'd40, 7'd127, 32'hDEAD, 1, wrapw);
        add(1, 1, 7'd60, 7'd3, 32'h1234, 1, wrapw);
        add(1, 0, 7'd0, 7'd126, 32'h0, 1, w5(32'hC, 32'hD, 32'hE, 32'h1234, 32'hFFFF0004));
        add(1, 0, 7'd124, 7'd0, 32'h0, 1, w5(32'hFFFF0004, 32'h0, 32'hA, 32'hB, 32'hC));

        rst = 1; en = 1; wr = 1; wa = 7'd9; wd = 32'h5555;
        @(posedge clk); #1;
        @(negedge clk); rst = 0; en = 0;
        check_win("reset", z);
        acc = 0;
        for (int i = 0; i < 128; i++) acc |= dut.REG[i];
        check("reset REG all zero", acc, 0);

        foreach (vq[i]) begin
            step(vq[i].en, vq[i].wr, vq[i].sa, vq[i].wa, vq[i].wd);
            if (vq[i].chk) check_win($sformatf("vec%0d", i), vq[i].e);
            if (i == 11)
                for (int a = 125; a < 128; a++) check($sformatf("REG[%0d] untouched", a), dut.REG[a], 0);
        end
        check("REG[126] after disabled cycles", dut.REG[126], 32'hA);

        for (int i = 0; i < 5; i++) step(1, 1, 0, 7'(i), 32'hFFFF0000 + i);
        step(1, 0, 7'd0, 0, 0);
        check_win("preload", w5(32'hFFFF0000, 32'hFFFF0001, 32'hFFFF0002, 32'hFFFF0003, 32'hFFFF0004));
        en = 1; wr = 1; wa = 7'd7; wd = 32'h7777;
        #2 rst = 1;
        #1;
        check_win("async reset", z);
        check("async reset REG[0]", dut.REG[0], 0);
        @(posedge clk); #1;
        check("write ignored in reset", dut.REG[7], 0);
        @(negedge clk); rst = 0;
        step(1, 0, 7'd0, 0, 0);
        check_win("read after reset", z);
        step(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_sipo.md
# regfile_sipo

Register file with a single write port and a five-wide parallel read window: one 32-bit word is written per cycle (serial in), and five consecutive words starting at a base address are presented together (parallel out). It sits in the datapath as the operand store feeding a five-operand consumer. A burst of sequential writes loads the window, and a single read request then delivers all five operands.

## Interface
Parameters:
- DATA_SIZE, 32, word width
- ADDR_SIZE, 7, address width
- REG_SIZE, 128 (2**ADDR_SIZE), number of words

Ports:
- clk  input  1  clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- reg_enable  input  1  qualifies any access this cycle
- reg_write  input  1  1 = write access, 0 = read access (valid only with reg_enable=1)
- src_addr  input  ADDR_SIZE  base address of the read window
- write_addr  input  ADDR_SIZE  write address
- write_data  input  DATA_SIZE  write data
- src1..src5  output  DATA_SIZE each  window words REG[src_addr+0] .. REG[src_addr+4]

The storage array is named REG, indexed 0..REG_SIZE-1, so benches can inspect it hierarchically.

## Operation
- Idle (reg_enable=0): nothing changes; REG and src1..src5 hold their values.
- Write (reg_enable=1, reg_write=1):
  - REG[write_addr] <= write_data.
  - src1..src5 hold.
- Read (reg_enable=1, reg_write=0):
  - srcK <= REG[(src_addr + K-1) mod REG_SIZE] for K=1..5.
  - REG is unchanged.
- Address arithmetic is ADDR_SIZE-bit unsigned and wraps.
  - Example: src_addr=126 yields REG[126], REG[127], REG[0], REG[1], REG[2].
- Read and write are mutually exclusive by encoding, so there is no same-cycle read/write hazard.
- write_addr is ignored during reads; src_addr is ignored during writes.
- Every address 0..127 is valid; there is no out-of-range case.

## Timing
- Reset (rst=1, asynchronous):
  - All REG entries clear to 0.
  - src1..src5 clear to 0 immediately.
  - All inputs are ignored while rst=1.
- Reset release: operation resumes at the first rising edge with rst=0.
- Write latency: the data is in REG after the rising edge where the write is sampled.
- Read latency: one cycle. src1..src5 update on the rising edge that samples the read and show REG contents as of before that edge.
  - A write at edge N is visible to a read sampled at edge N+1 or later.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-burst aborts the burst. Writes not yet clocked are lost, and everything clears.

## Structure
- Shared package:
  - DATA_SIZE, ADDR_SIZE, REG_SIZE.
  - Read-window width constant WINDOW=5.
  - Word and address typedefs.
- One natural sub-module, regfile_window_mux:
  - Combinational; takes the REG array and base address.
  - Produces the five wrapped-index words.
- The top level holds the REG array, the write logic and the output registers.

## Test plan
- Reset: rst=1 for 1 cycle, then release. Required: src1..src5=0 and REG[0..127]=0.
- Sequential write, read at base 0:
  - Write addresses 0..4 with data 0xFFFF0000..0xFFFF0004, then read src_addr=0.
  - Required one cycle later: src1..src5 = 0xFFFF0000..0xFFFF0004.
- High-address window:
  - Write addresses 120..124 with 0xFFFF0000..0xFFFF0004, then read src_addr=120.
  - Required: src1..src5 = 0xFFFF0000..0xFFFF0004, and REG[125..127] remain 0.
- Wrap-around:
  - Write REG[126]=0xA, REG[127]=0xB, REG[0]=0xC, REG[1]=0xD, REG[2]=0xE, then read src_addr=126.
  - Required: src1..src5 = 0xA, 0xB, 0xC, 0xD, 0xE.
- Hold and disable:
  - After a read, drive reg_enable=0 with a different src_addr and reg_write=1 for 3 cycles.
  - Required: outputs unchanged and REG unchanged.
  - A write with reg_enable=1 must leave src1..src5 unchanged.
- Async reset mid-operation:
  - Assert rst between clock edges after loading 0..4.
  - Required: outputs go to 0 before the next edge, and a following read at 0 returns all zeros.
